dnn_layer_accel: RTL and testbench
==================================

// Module: dnn_layer_accel
// PURPOSE
//  Parametrised fully-connected layer engine for the DNN accelerator system: out[j] = act(bias[j] + sum_i w[j][i]*x[i]).
//  Sits on the Avalon fabric: CPU programs it via an MM slave; it reads bias/weights/activations from and writes outputs to SDRAM via an MM master.
//  Successor to the single dot-product engine: whole layer (N_OUT neurons) per start, configurable fixed-point format, optional ReLU.
// PARAMETERS
//  DATA_W    32  signed fixed-point word width (all operands/results)
//  FRAC_BITS 16  fractional bits (Q(DATA_W-FRAC_BITS).FRAC_BITS)
//  ADDR_W    32  master byte-address width
//  CNT_W     16  width of n_in / n_out counters
// PORTS
//  clk                  in   1       system clock
//  reset                in   1       asynchronous, active-high reset
//  slave_address        in   4       word offset of config register
//  slave_read           in   1       slave read strobe (readdata combinational, latency 0)
//  slave_write          in   1       slave write strobe
//  slave_writedata      in   DATA_W  write data
//  slave_readdata       out  DATA_W  read data
//  master_address       out  ADDR_W  byte address, word-aligned
//  master_read          out  1       read request, held until !waitrequest
//  master_write         out  1       write request, held until !waitrequest
//  master_writedata     out  DATA_W  output neuron value
//  master_readdata      in   DATA_W  returned read data
//  master_waitrequest   in   1       fabric stall
//  master_readdatavalid in   1       read data valid (variable latency)
// BEHAVIOUR
//  Regs: 0 CTRL (wr any=start; rd {0,done}), 1 BIAS_ADDR, 2 W_ADDR, 3 IN_ADDR, 4 OUT_ADDR, 5 N_IN, 6 N_OUT, 7 RELU[0]; rd unmapped=0.
//  Reset: all regs 0, done=1, state IDLE, master_read/write=0, master_address/writedata=0.
//  Writes to regs 0-7 while busy (done=0) ignored; start clears done on next edge.
//  Layout: bias[j]@BIAS+4j; w[j][i]@W+4(j*N_IN+i) row-major; x[i]@IN+4i; out[j]@OUT+4j.
//  FSM: IDLE -> (start) CHK -> RD_BIAS -> {RD_W -> RD_X -> MAC}*N_IN -> WR_OUT -> (j<N_OUT-1) RD_BIAS | DONE -> IDLE.
//  Read: assert read+address until waitrequest=0; then wait readdatavalid; exactly one outstanding read.
//  Write: hold write/address/data until waitrequest=0.
//  MAC: p=(w*x) full 2*DATA_W signed, >>>FRAC_BITS (floor), low DATA_W bits; acc=acc+p mod 2^DATA_W; acc init=bias[j].
//  ReLU: if RELU[0] and acc<0 write 0, else acc.
//  N_OUT=0: CHK->DONE, zero master transactions, done=1 within 2 cycles of start.
//  N_IN=0: out[j]=act(bias[j]), no weight/activation reads.
//  readdatavalid while not awaiting data: ignored. Reset mid-op: strobes drop immediately (async), transaction abandoned.
// CONFIGURATION
//  ACC_SATURATE_EN defined: product truncation and every accumulate clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  Not defined: two's-complement wrap as above; no extra logic.
// STRUCTURE
//  Package dnn_accel_pkg: FSM state enum, register offset constants, Q-format helpers (ONE=1<<FRAC_BITS, MAX/MIN values).
//  Sub-module dnn_mac_unit: combinational multiply-shift + registered accumulator, load/clear/en, saturation under ACC_SATURATE_EN.
// TESTING
//  N_IN=2,N_OUT=1,w={0x00010000,0x00020000},x={0x00008000,0x00004000},bias=0x00002000 -> out 0x00012000, done=1.
//  N_IN=1,w=x=0x00010000,bias=0xFFFD0000: RELU=1 -> 0x00000000; RELU=0 -> 0xFFFE0000.
//  N_OUT=0 start -> no master_read/write ever asserted, CTRL reads 1 within 2 cycles.
//  4x3 layer, random waitrequest (50%) and readdatavalid latency 1-5 -> outputs match golden model, 1 read outstanding max.
//  Reset pulsed during RD_W -> master_read=0 same cycle, done=1, all regs 0; fresh start then completes correctly.
//  w=x=0x7FFF0000,bias=0: without ACC_SATURATE_EN -> wrapped low 32 bits; with it -> 0x7FFFFFFF.

Source files
------------

// File: rtl/dnn_accel_pkg.sv
// Shared definitions for the fully-connected layer engine: FSM state codes,
// CSR word offsets and Q-format helpers for the default 32-bit Q16.16 format.
package dnn_accel_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHK     = 3'd1;
  localparam logic [2:0] ST_RD_BIAS = 3'd2;
  localparam logic [2:0] ST_RD_W    = 3'd3;
  localparam logic [2:0] ST_RD_X    = 3'd4;
  localparam logic [2:0] ST_MAC     = 3'd5;
  localparam logic [2:0] ST_WR_OUT  = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  // CSR word offsets
  localparam logic [3:0] REG_CTRL      = 4'd0;
  localparam logic [3:0] REG_BIAS_ADDR = 4'd1;
  localparam logic [3:0] REG_W_ADDR    = 4'd2;
  localparam logic [3:0] REG_IN_ADDR   = 4'd3;
  localparam logic [3:0] REG_OUT_ADDR  = 4'd4;
  localparam logic [3:0] REG_N_IN      = 4'd5;
  localparam logic [3:0] REG_N_OUT     = 4'd6;
  localparam logic [3:0] REG_RELU      = 4'd7;

  // Q16.16 helpers
  localparam int          Q_FRAC_BITS = 16;
  localparam logic [31:0] Q_ONE       = 32'(1) << Q_FRAC_BITS;
  localparam logic [31:0] Q_MAX       = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN       = 32'h8000_0000;

  function automatic logic [31:0] q_from_int(input int v);
    return 32'(v) << Q_FRAC_BITS;
  endfunction

endpackage

// File: rtl/dnn_layer_accel_if.sv
// Avalon-MM style bus bundle. Used twice by the accelerator: once as the
// CPU-facing config slave (AW=4 word offset) and once as the SDRAM master.
interface dnn_layer_accel_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          waitrequest;
  logic          readdatavalid;

  modport master (output address, read, write, writedata,
                  input  readdata, waitrequest, readdatavalid);
  modport slave  (input  address, read, write, writedata,
                  output readdata, waitrequest, readdatavalid);
endinterface

// File: rtl/dnn_mac_unit.sv
// Multiply-accumulate datapath: combinational Q-format multiply with floor
// shift, registered accumulator with clear/load/accumulate controls.
// Build option: ACC_SATURATE_EN clamps the product and each accumulate to the
// signed DATA_W range instead of wrapping.
module dnn_mac_unit #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] load_val_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_o
);
  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] a_x, b_x;
  logic [DATA_W-1:0]    prod_w, sum_w, acc_q, acc_d;

  assign a_x = PW'($signed(a_i));
  assign b_x = PW'($signed(b_i));

`ifdef ACC_SATURATE_EN
  localparam logic [DATA_W-1:0] MAX_W = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_W = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [PW-1:0] PMAX = PW'($signed(MAX_W));
  localparam logic signed [PW-1:0] PMIN = PW'($signed(MIN_W));

  logic signed [PW-1:0] prod_sh;
  logic [DATA_W:0]      sum_x;

  // Clamp shifted product, then clamp the sum on signed overflow
  always_comb begin
    prod_sh = (a_x * b_x) >>> FRAC_BITS;
    if (prod_sh > PMAX)      prod_w = MAX_W;
    else if (prod_sh < PMIN) prod_w = MIN_W;
    else                     prod_w = prod_sh[DATA_W-1:0];
    sum_x = {acc_q[DATA_W-1], acc_q} + {prod_w[DATA_W-1], prod_w};
    if (sum_x[DATA_W] != sum_x[DATA_W-1]) sum_w = sum_x[DATA_W] ? MIN_W : MAX_W;
    else                                  sum_w = sum_x[DATA_W-1:0];
  end
`else
  // Two's-complement wrap: keep the low DATA_W bits of product and sum
  always_comb begin
    prod_w = DATA_W'((a_x * b_x) >>> FRAC_BITS);
    sum_w  = acc_q + prod_w;
  end
`endif

  // Accumulator next value: clear beats load beats accumulate
  always_comb begin
    acc_d = acc_q;
    if (clr_i)       acc_d = '0;
    else if (load_i) acc_d = load_val_i;
    else if (en_i)   acc_d = sum_w;
  end

  // Accumulator register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/dnn_layer_accel.sv
// Fully-connected layer engine: out[j] = act(bias[j] + sum_i w[j][i]*x[i]).
// CPU programs it through the config slave; operands and results move over
// the memory master with one outstanding read at a time.
// Build option: ACC_SATURATE_EN (saturating MAC, see dnn_mac_unit).
module dnn_layer_accel
  import dnn_accel_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               reset,
  dnn_layer_accel_if.slave  slave,
  dnn_layer_accel_if.master master
);
  localparam logic [ADDR_W-1:0] WSTEP = ADDR_W'(4);

  logic [2:0]        state_q, state_d;
  logic              done_q, done_d, pend_q, pend_d, relu_q, relu_d;
  logic [ADDR_W-1:0] bias_addr_q, bias_addr_d, w_addr_q, w_addr_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d, out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] b_ptr_q, b_ptr_d, w_ptr_q, w_ptr_d;
  logic [ADDR_W-1:0] x_ptr_q, x_ptr_d, o_ptr_q, o_ptr_d;
  logic [CNT_W-1:0]  n_in_q, n_in_d, n_out_q, n_out_d, i_q, i_d, j_q, j_d;
  logic [DATA_W-1:0] w_q, w_d, x_q, x_d, acc, act;
  logic              mac_clr, mac_load, mac_en;
  logic              rd_state, rd_issue, rd_done;

  // Read handshake: request until accepted, then wait for the data beat
  assign rd_state = (state_q == ST_RD_BIAS) || (state_q == ST_RD_W) || (state_q == ST_RD_X);
  assign rd_issue = rd_state && !pend_q;
  assign rd_done  = rd_state && pend_q && master.readdatavalid;

  assign act = (relu_q && acc[DATA_W-1]) ? '0 : acc;

  dnn_mac_unit #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (mac_clr),
    .load_i    (mac_load),
    .en_i      (mac_en),
    .load_val_i(master.readdata),
    .a_i       (w_q),
    .b_i       (x_q),
    .acc_o     (acc)
  );

  // Next-state: CSR writes while idle, read handshake, layer sequencing
  always_comb begin
    state_d = state_q;  done_d = done_q;  pend_d = pend_q;  relu_d = relu_q;
    bias_addr_d = bias_addr_q;  w_addr_d = w_addr_q;
    in_addr_d = in_addr_q;  out_addr_d = out_addr_q;
    n_in_d = n_in_q;  n_out_d = n_out_q;  i_d = i_q;  j_d = j_q;
    b_ptr_d = b_ptr_q;  w_ptr_d = w_ptr_q;  x_ptr_d = x_ptr_q;  o_ptr_d = o_ptr_q;
    w_d = w_q;  x_d = x_q;
    mac_clr = 1'b0;  mac_load = 1'b0;  mac_en = 1'b0;

    // done_q is high exactly while idle, so it gates config writes
    if (slave.write && done_q) begin
      case (slave.address)
        REG_CTRL:      begin done_d = 1'b0; state_d = ST_CHK; end
        REG_BIAS_ADDR: bias_addr_d = ADDR_W'(slave.writedata);
        REG_W_ADDR:    w_addr_d    = ADDR_W'(slave.writedata);
        REG_IN_ADDR:   in_addr_d   = ADDR_W'(slave.writedata);
        REG_OUT_ADDR:  out_addr_d  = ADDR_W'(slave.writedata);
        REG_N_IN:      n_in_d      = CNT_W'(slave.writedata);
        REG_N_OUT:     n_out_d     = CNT_W'(slave.writedata);
        REG_RELU:      relu_d      = slave.writedata[0];
        default: ;
      endcase
    end

    if (rd_issue && !master.waitrequest) pend_d = 1'b1;
    if (rd_done)                         pend_d = 1'b0;

    case (state_q)
      ST_CHK: begin
        b_ptr_d = bias_addr_q;  w_ptr_d = w_addr_q;  o_ptr_d = out_addr_q;
        j_d     = '0;
        mac_clr = 1'b1;
        state_d = (n_out_q == '0) ? ST_DONE : ST_RD_BIAS;
      end
      ST_RD_BIAS: if (rd_done) begin
        mac_load = 1'b1;
        x_ptr_d  = in_addr_q;
        i_d      = '0;
        state_d  = (n_in_q == '0) ? ST_WR_OUT : ST_RD_W;
      end
      ST_RD_W: if (rd_done) begin
        w_d     = master.readdata;
        w_ptr_d = w_ptr_q + WSTEP;
        state_d = ST_RD_X;
      end
      ST_RD_X: if (rd_done) begin
        x_d     = master.readdata;
        x_ptr_d = x_ptr_q + WSTEP;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        mac_en  = 1'b1;
        i_d     = i_q + CNT_W'(1);
        state_d = (i_q == n_in_q - CNT_W'(1)) ? ST_WR_OUT : ST_RD_W;
      end
      ST_WR_OUT: if (!master.waitrequest) begin
        if (j_q == n_out_q - CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + CNT_W'(1);
          b_ptr_d = b_ptr_q + WSTEP;
          o_ptr_d = o_ptr_q + WSTEP;
          state_d = ST_RD_BIAS;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;  done_q <= 1'b1;  pend_q <= 1'b0;  relu_q <= 1'b0;
      bias_addr_q <= '0;  w_addr_q <= '0;  in_addr_q <= '0;  out_addr_q <= '0;
      n_in_q <= '0;  n_out_q <= '0;  i_q <= '0;  j_q <= '0;
      b_ptr_q <= '0;  w_ptr_q <= '0;  x_ptr_q <= '0;  o_ptr_q <= '0;
      w_q <= '0;  x_q <= '0;
    end else begin
      state_q <= state_d;  done_q <= done_d;  pend_q <= pend_d;  relu_q <= relu_d;
      bias_addr_q <= bias_addr_d;  w_addr_q <= w_addr_d;
      in_addr_q <= in_addr_d;  out_addr_q <= out_addr_d;
      n_in_q <= n_in_d;  n_out_q <= n_out_d;  i_q <= i_d;  j_q <= j_d;
      b_ptr_q <= b_ptr_d;  w_ptr_q <= w_ptr_d;  x_ptr_q <= x_ptr_d;  o_ptr_q <= o_ptr_d;
      w_q <= w_d;  x_q <= x_d;
    end
  end

  // Master outputs decode from registered state only, so reset drops them at once
  always_comb begin
    case (state_q)
      ST_RD_BIAS: master.address = b_ptr_q;
      ST_RD_W:    master.address = w_ptr_q;
      ST_RD_X:    master.address = x_ptr_q;
      ST_WR_OUT:  master.address = o_ptr_q;
      default:    master.address = '0;
    endcase
  end

  assign master.read      = rd_issue;
  assign master.write     = (state_q == ST_WR_OUT);
  assign master.writedata = (state_q == ST_WR_OUT) ? act : '0;

  // Zero-latency CSR readback
  always_comb begin
    slave.readdata = '0;
    if (slave.read) begin
      case (slave.address)
        REG_CTRL:      slave.readdata = DATA_W'(done_q);
        REG_BIAS_ADDR: slave.readdata = DATA_W'(bias_addr_q);
        REG_W_ADDR:    slave.readdata = DATA_W'(w_addr_q);
        REG_IN_ADDR:   slave.readdata = DATA_W'(in_addr_q);
        REG_OUT_ADDR:  slave.readdata = DATA_W'(out_addr_q);
        REG_N_IN:      slave.readdata = DATA_W'(n_in_q);
        REG_N_OUT:     slave.readdata = DATA_W'(n_out_q);
        REG_RELU:      slave.readdata = DATA_W'(relu_q);
        default:       slave.readdata = '0;
      endcase
    end
  end

  assign slave.waitrequest   = 1'b0;
  assign slave.readdatavalid = 1'b0;
endmodule

// File: tb/tb_dnn_layer_accel.sv
// Bench for dnn_layer_accel: SDRAM model with random stalls and read latency,
// scoreboard of expected output writes fed from a arithmetic reference model.
module tb_dnn_layer_accel;
  import dnn_accel_pkg::*;

  localparam int FRAC = 16;
  localparam logic [31:0] B_BASE = 32'h000, W_BASE = 32'h100;
  localparam logic [31:0] I_BASE = 32'h800, O_BASE = 32'hC00;
  localparam longint LMAX = 64'sh7FFFFFFF;
  localparam longint LMIN = -LMAX - 1;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

  logic clk = 0, reset = 1;
  always #5 clk = ~clk;

  dnn_layer_accel_if #(.AW(4),  .DW(32)) csr ();
  dnn_layer_accel_if #(.AW(32), .DW(32)) mem ();

  dnn_layer_accel #(.DATA_W(32), .FRAC_BITS(16), .ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .slave(csr), .master(mem));

  int total = 0, bad = 0;
  wr_t exp_q[$], obs_q[$];
  logic [31:0] mem_arr [0:1023];
  logic [31:0] b_v [0:15], w_v [0:63], x_v [0:15];
  bit stall_en = 0;
  int strobe_cnt = 0, rd_count = 0;
  bit pend_busy = 0;
  int pend_cnt = 0;
  logic [31:0] pend_data = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > LMAX) return LMAX;
    if (v < LMIN) return LMIN;
    return v;
  endfunction

  // Reference neuron straight from the layer equation
  function automatic logic [31:0] ref_neuron(input int j, input int nin, input bit relu);
    longint acc, p;
    acc = longint'($signed(b_v[j]));
    for (int i = 0; i < nin; i++) begin
      p = (longint'($signed(w_v[j*nin+i])) * longint'($signed(x_v[i]))) >>> FRAC;
`ifdef ACC_SATURATE_EN
      acc = clamp(acc + clamp(p));
`else
      acc = longint'(int'(acc + p));
`endif
    end
    if (relu && acc < 0) return 32'h0;
    return 32'(acc);
  endfunction

  function automatic logic [31:0] rnd_q();
    return 32'($urandom_range(0, 32'h000C0000)) - 32'h00060000;
  endfunction

  // SDRAM model: decisions for the coming edge are made on the falling edge
  always @(negedge clk) begin
    if (reset) begin
      pend_busy = 0;
      mem.waitrequest = 0; mem.readdatavalid = 0; mem.readdata = '0;
    end else begin
      mem.readdatavalid = 0;
      mem.readdata = $urandom;
      if (pend_busy) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem.readdatavalid = 1; mem.readdata = pend_data; pend_busy = 0;
        end
      end else if (stall_en && $urandom_range(0, 9) == 0) begin
        mem.readdatavalid = 1;  // stray beat, must be ignored
      end
      mem.waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mem.read || mem.write) strobe_cnt++;
      if (mem.read && !mem.waitrequest) begin
        chk("outstanding", {31'b0, pend_busy}, 32'd0);
        pend_busy = 1;
        pend_cnt  = stall_en ? $urandom_range(1, 5) : 1;
        pend_data = mem_arr[mem.address[11:2]];
        rd_count++;
      end
      if (mem.write && !mem.waitrequest) begin
        mem_arr[mem.address[11:2]] = mem.writedata;
        obs_q.push_back('{a: mem.address, d: mem.writedata});
      end
    end
  end

  // Scoreboard monitor
  always @(posedge clk) begin
    while (obs_q.size() > 0) begin
      wr_t o, e;
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        chk("unexpected write", o.a, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out addr", o.a, e.a);
        chk("out data", o.d, e.d);
      end
    end
  end

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    csr.address = a; csr.writedata = d; csr.write = 1;
    @(negedge clk);
    csr.write = 0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    csr.address = a; csr.read = 1;
    #1 d = csr.readdata;
    csr.read = 0;
  endtask

  task automatic wait_done();
    logic [31:0] d;
    d = 0;
    for (int c = 0; c < 3000; c++) begin
      csr_rd(REG_CTRL, d);
      if (d[0]) break;
    end
    chk("done", d, 32'd1);
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_and_start(input int nin, input int nout, input bit relu);
    @(negedge clk);
    for (int j = 0; j < nout; j++) mem_arr[(B_BASE >> 2) + j] = b_v[j];
    for (int k = 0; k < nin*nout; k++) mem_arr[(W_BASE >> 2) + k] = w_v[k];
    for (int i = 0; i < nin; i++) mem_arr[(I_BASE >> 2) + i] = x_v[i];
    for (int j = 0; j < nout; j++) begin
      mem_arr[(O_BASE >> 2) + j] = 32'hDEADBEEF;
      exp_q.push_back('{a: O_BASE + 32'(4*j), d: ref_neuron(j, nin, relu)});
    end
    csr_wr(REG_BIAS_ADDR, B_BASE); csr_wr(REG_W_ADDR, W_BASE);
    csr_wr(REG_IN_ADDR, I_BASE);   csr_wr(REG_OUT_ADDR, O_BASE);
    csr_wr(REG_N_IN, 32'(nin));    csr_wr(REG_N_OUT, 32'(nout));
    csr_wr(REG_RELU, {31'b0, relu});
    csr_wr(REG_CTRL, 32'd1);
  endtask

  task automatic run_layer(input int nin, input int nout, input bit relu);
    logic [31:0] d;
    load_and_start(nin, nout, relu);
    csr_wr(REG_N_OUT, 32'h55);  // busy: must be dropped
    wait_done();
    csr_rd(REG_N_OUT, d);
    chk("busy write ignored", d, 32'(nout));
  endtask

  initial begin
    logic [31:0] d;
    int base, found;
    csr.address = 0; csr.read = 0; csr.write = 0; csr.writedata = 0;
    repeat (3) @(negedge clk);
    #2 reset = 0;

    // Reset state
    chk("rst read",  {31'b0, mem.read},  32'd0);
    chk("rst write", {31'b0, mem.write}, 32'd0);
    chk("rst addr",  mem.address,   32'd0);
    chk("rst wdata", mem.writedata, 32'd0);
    for (int a = 0; a < 8; a++) begin
      csr_rd(4'(a), d);
      chk("rst reg", d, (a == 0) ? 32'd1 : 32'd0);
    end

    // Two-input neuron
    b_v[0] = 32'h00002000;
    w_v[0] = 32'h00010000; w_v[1] = 32'h00020000;
    x_v[0] = 32'h00008000; x_v[1] = 32'h00004000;
    run_layer(2, 1, 0);
    chk("directed out", mem_arr[O_BASE >> 2], 32'h00012000);
    csr_rd(REG_W_ADDR, d); chk("w addr readback", d, W_BASE);
    csr_rd(4'd12, d);      chk("unmapped reg", d, 32'd0);

    // ReLU on / off with negative result
    b_v[0] = 32'hFFFD0000; w_v[0] = Q_ONE; x_v[0] = Q_ONE;
    run_layer(1, 1, 1);
    chk("relu on", mem_arr[O_BASE >> 2], 32'h00000000);
    run_layer(1, 1, 0);
    chk("relu off", mem_arr[O_BASE >> 2], 32'hFFFE0000);

    // Large product: wraps or saturates depending on build
    b_v[0] = 0; w_v[0] = 32'h7FFF0000; x_v[0] = 32'h7FFF0000;
    run_layer(1, 1, 0);
`ifdef ACC_SATURATE_EN
    chk("big product", mem_arr[O_BASE >> 2], Q_MAX);
`else
    chk("big product", mem_arr[O_BASE >> 2], 32'h00010000);
`endif

    // Empty layer: no bus traffic, done within two cycles
    base = strobe_cnt;
    csr_wr(REG_N_OUT, 32'd0);
    csr_wr(REG_CTRL, 32'd1);
    @(negedge clk);
    csr_rd(REG_CTRL, d);
    chk("n_out=0 done", d, 32'd1);
    repeat (4) @(negedge clk);
    chk("n_out=0 strobes", 32'(strobe_cnt - base), 32'd0);

    // Random 4x3 layers with stalls and variable latency
    stall_en = 1;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) b_v[j] = rnd_q();
      for (int k = 0; k < 12; k++) w_v[k] = rnd_q();
      for (int i = 0; i < 3; i++) x_v[i] = rnd_q();
      run_layer(3, 4, 1'($urandom_range(0, 1)));
    end

    // Bias-only layer: one read per neuron
    base = rd_count;
    for (int j = 0; j < 3; j++) b_v[j] = rnd_q();
    run_layer(0, 3, 1);
    chk("n_in=0 reads", 32'(rd_count - base), 32'd3);

    // Reset in the middle of a weight read
    for (int j = 0; j < 4; j++) b_v[j] = rnd_q();
    for (int k = 0; k < 12; k++) w_v[k] = rnd_q();
    for (int i = 0; i < 3; i++) x_v[i] = rnd_q();
    load_and_start(3, 4, 0);
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (mem.read && mem.address >= W_BASE && mem.address < W_BASE + 48) found = 1;
    end
    chk("reached weight read", 32'(found), 32'd1);
    #1 reset = 1;
    #1 chk("reset drops read", {31'b0, mem.read}, 32'd0);
    exp_q.delete();
    for (int a = 0; a < 8; a++) begin
      csr_rd(4'(a), d);
      chk("mid-op reset reg", d, (a == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    #2 reset = 0;
    run_layer(3, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
